// File: rtl/debounce_sync.sv
// Debouncer for a raw asynchronous 1-bit input: synchronizer chain, then a
// qualification FSM that only lets q follow a level held for STABLE_CYCLES clocks.
module debounce_sync #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic          DIRECT   = (STABLE_CYCLES == 1);

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  state_t                 state_r, state_nx;
  logic [CW-1:0]          cnt_r, cnt_nx;
  logic                   q_r, q_nx;
  logic                   rise_r, rise_nx;
  logic                   fall_r, fall_nx;
  logic                   busy_r, busy_nx;
  logic                   upd_s;

  assign s_s = sync_r[SYNC_STAGES-1];

  // Synchronizer chain: flops only between din and s.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  // Qualification FSM next-state and output decode.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    upd_s    = 1'b0;
    case (state_r)
      STABLE: begin
        if (s_s != q_r) begin
          if (DIRECT) begin
            upd_s = 1'b1;
          end else begin
            cnt_nx   = CNT_ONE;
            state_nx = CHECK;
          end
        end else begin
          cnt_nx = CNT_ZERO;
        end
      end
      CHECK: begin
        // Any return to q discards all accumulated credit.
        if (s_s == q_r) begin
          cnt_nx   = CNT_ZERO;
          state_nx = STABLE;
        end else if (cnt_r == CNT_LAST) begin
          upd_s    = 1'b1;
          cnt_nx   = CNT_ZERO;
          state_nx = STABLE;
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
      default: begin
        cnt_nx   = CNT_ZERO;
        state_nx = STABLE;
      end
    endcase
    q_nx    = upd_s ? s_s : q_r;
    rise_nx = upd_s & s_s;
    fall_nx = upd_s & ~s_s;
    busy_nx = (state_nx == CHECK);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= STABLE;
      cnt_r   <= CNT_ZERO;
      q_r     <= RESET_LEVEL;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      q_r     <= q_nx;
      rise_r  <= rise_nx;
      fall_r  <= fall_nx;
      busy_r  <= busy_nx;
    end
  end

  assign q    = q_r;
  assign rise = rise_r;
  assign fall = fall_r;
  assign busy = busy_r;

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw, asynchronous, possibly bouncing 1-bit input (push-button, switch, external strobe) into a clean, clock-synchronous level.
- Also produces single-cycle edge pulses.
- Sits directly upstream of the team's D flip-flop stages: its q output drives their d input, so downstream registers only ever see a metastability-free, glitch-filtered signal.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on din (legal ≥2).
- STABLE_CYCLES, 16, consecutive synchronized cycles din must hold a new value before q follows (legal ≥1).
- RESET_LEVEL, 0, value of q and every synchronizer flop during reset (1-bit).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset; asynchronous and active-high.
- din  input  1  raw asynchronous input, no timing relation to clk.
- q  output  1  debounced, synchronized level.
- rise  output  1  one-cycle pulse, high in the cycle q goes 0→1.
- fall  output  1  one-cycle pulse, high in the cycle q goes 1→0.
- busy  output  1  high while a candidate change is being qualified (state CHECK).

Behaviour:
- Reset (asynchronous, active-high):
  - Takes effect immediately on rst rising, with no clock edge needed.
  - Sync chain = RESET_LEVEL, q = RESET_LEVEL, rise = fall = 0, busy = 0, counter = 0, state = STABLE.
  - Held while rst = 1.
  - Deassertion needs no special handling; the first rising edge after release resumes normal operation.
- Synchronizer:
  - din passes through SYNC_STAGES flops; s = last stage.
  - No logic other than flops between din and s.
- Counter: width $clog2(STABLE_CYCLES+1). Counts rising edges at which s != q.
- FSM states: STABLE, CHECK. All outputs registered; busy = (state == CHECK).
- STABLE:
  - If s != q: counter ← 1, go to CHECK.
  - Exception: if STABLE_CYCLES == 1, update q immediately (see "q update") and remain in STABLE.
  - If s == q: hold, counter = 0.
- CHECK:
  - If s == q: glitch rejected. Counter ← 0, go to STABLE, q unchanged, no pulse.
  - Else if counter + 1 == STABLE_CYCLES: perform q update, counter ← 0, go to STABLE.
  - Else: counter ← counter + 1.
- q update:
  - q ← s on that edge.
  - Pulses, registered in the same edge as the q change:
    - rise = 1 for exactly one cycle if the new q = 1.
    - fall = 1 for exactly one cycle if the new q = 0.
  - rise and fall are never both high. Neither is high when q does not change.
- Latency:
  - Number the first rising edge that samples a new, held din as edge 1.
  - s changes after edge SYNC_STAGES.
  - q changes at edge SYNC_STAGES + STABLE_CYCLES. Defaults: edge 18.
  - busy is high from edge SYNC_STAGES+1 until edge SYNC_STAGES+STABLE_CYCLES, where it returns low.
- Bounce: any return of s to q before qualification restarts qualification from zero. No partial credit is carried over.
- s changing exactly at the qualifying edge: the decision uses the s value sampled at that edge.
- Reset mid-CHECK: counter, busy and state are cleared immediately, and q returns to RESET_LEVEL. After release, a din held at the opposite level is re-qualified in full (18 edges with defaults).
- No wrap-around is possible: the counter never exceeds STABLE_CYCLES-1 before leaving CHECK.

Test Plan:
1. Async reset:
   - Stimulus: din = 1, run clocks, then raise rst 3 ns after a rising edge while clk is low.
   - Required: q = 0, rise = fall = busy = 0 before the next clock edge; values held for 5 edges while rst = 1.
2. Clean rise and fall (defaults):
   - Stimulus: din 0→1 held.
   - Required: q = 1 and rise = 1 at edge 18, rise = 0 at edge 19, busy high from edge 3 through 17. Then din 1→0 held → q = 0 and fall = 1 at edge 18.
3. Glitch reject:
   - Stimulus: din = 1 for 10 cycles, then 0.
   - Required: q stays 0, rise never asserts, busy drops within 3 edges of din falling.
4. Bounce:
   - Stimulus: din toggles every 3 cycles for 30 cycles, then settles at 1.
   - Required: exactly one rise pulse total; q = 1 at edge 18 counted from the settle point; no fall pulse.
5. Reset mid-CHECK:
   - Stimulus: din = 1 held; assert rst 3 ns after the edge where busy has been high for 10 cycles; release after 2 cycles.
   - Required: busy = 0 and q = 0 immediately on rst. After release, q = 1 at edge 18 counted from the first post-release edge, with one rise pulse.
6. Minimum configuration:
   - Setup: SYNC_STAGES = 2, STABLE_CYCLES = 1.
   - Stimulus: din 0→1.
   - Required: q = 1 and rise = 1 at edge 3; busy never asserts.
